mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Responder side of the word-level memory request interface used by the IF and MEM stages.
- Accepts read requests from IF, and read or write requests from MEM, each 1, 2 or 4 bytes, little-endian.
- Arbitrates between the two stages and serialises each request into byte transactions on the CPU's 8-bit RAM/IO bus (mem_a/mem_dout/mem_din/mem_wr).
- Returns a one-cycle done pulse with assembled read data; honours rdy_in pause and IF flush on jump.

Parameters:
ADDR_WIDTH, 32, width of request addresses and of mem_a.

Ports:
clk_in  input  1  system clock.
rst_in  input  1  synchronous, active-high reset.
rdy_in  input  1  pause when low.
if_req_in  input  1  IF read request; held until if_done_out or flush.
if_addr_in  input  32  IF fetch address; always a 4-byte read.
if_flush_in  input  1  abort pending/in-flight IF read (pc jump).
if_done_out  output  1  one-cycle pulse; rdata_out holds the instruction.
ls_req_in  input  1  MEM request; held with stable fields until ls_done_out.
ls_we_in  input  1  1 = write, 0 = read.
ls_len_in  input  2  00 = byte, 01 = half, 10 = word; 11 is illegal and treated as word.
ls_addr_in  input  32  byte address; unaligned addresses are allowed.
ls_wdata_in  input  32  write data; low len bytes are used.
ls_done_out  output  1  one-cycle completion pulse.
rdata_out  output  32  assembled read data, shared by both requesters.
mem_din  input  8  bus read byte.
mem_dout  output  8  bus write byte.
mem_a  output  32  bus address.
mem_wr  output  1  1 = write; combinationally gated as wr_reg AND rdy_in.

Behaviour:
- Reset (rst_in high at an edge): state=IDLE; mem_a=0, mem_dout=0, wr_reg=0, if_done_out=0, ls_done_out=0, rdata_out=0, byte counter=0.
- States: IDLE, READ, WRITE, DONE. N = 1/2/4 bytes.
- IDLE accept (cycle 0):
  - ls_req_in wins over if_req_in.
  - if_req_in is ignored when if_flush_in is high in the same cycle.
  - Request fields are latched on acceptance; the requester sees the done pulse against them.
- READ: non-overlapped, 2 cycles per byte.
  - Byte i: mem_a = addr+i during cycles 1+2i and 2+2i.
  - mem_din is captured into rdata_out[8i+7:8i] at the end of cycle 2+2i.
  - At that same edge, mem_a advances to addr+i+1.
  - Unused upper bytes of rdata_out are cleared to 0; sign extension belongs to the MEM stage.
  - Done in cycle 2N+1: word = 9, half = 5, byte = 3.
- WRITE:
  - Byte i: mem_a = addr+i, mem_dout = wdata[8i+7:8i], wr_reg=1 in cycle 1+i.
  - wr_reg=0 in the DONE cycle.
  - Done in cycle N+1 (word = 5).
- DONE:
  - The requester's done pulse is high for exactly this cycle; rdata_out is stable and held until the next read completes.
  - No request is accepted in DONE; the state returns to IDLE, and the earliest next accept is cycle 2N+2 (read) or N+2 (write).
- Address arithmetic: addr+i is a 32-bit add with natural wrap (0xFFFFFFFF+1 = 0). No alignment checks.
- rdy_in low:
  - All registers are frozen and mem_wr is forced to 0.
  - A write byte presented in a paused cycle is re-presented after resume, so each byte is written exactly once.
  - A read capture is deferred; mem_a is held, so mem_din remains valid for the same byte.
- if_flush_in high while serving an IF read (READ state): abort and go to IDLE at the next edge with no if_done_out. Partial rdata_out contents are don't-care.
- if_flush_in in DONE: no effect on the pulse.
- Flush never affects MEM requests; writes are never aborted.
- The controller never asserts both done outputs in the same cycle.

Decomposition:
- Shared package holds:
  - The len encoding constants (LEN_BYTE/LEN_HALF/LEN_WORD).
  - The state enum.
  - The byte-count function len -> N.
- No sub-module is natural: a single FSM plus a 2-bit byte counter and a phase bit.

Test Plan:
- IF word read at 0x1000 with RAM bytes 13,00,00,93 (addr order) -> if_done_out in cycle 9, rdata_out=0x93000013, mem_a steps 0x1000..0x1003 every 2 cycles.
- MEM byte write 0x30000 data 0x41 -> mem_wr high exactly one cycle (cycle 1) with mem_dout=0x41; ls_done_out in cycle 2.
- Simultaneous if_req_in and ls_req_in (half read at 0x2002 = 0xBEEF) -> MEM served first, ls_done_out in cycle 5, rdata_out=0x0000BEEF; IF accepted in cycle 6, done in cycle 15.
- rdy_in low for 3 cycles during byte 1 of a word write -> each address 0x100..0x103 is written exactly once (count mem_wr&rdy_in pulses = 4); done delayed by 3 cycles.
- if_flush_in at cycle 4 of an IF read -> no if_done_out; a new if_req_in at 0x2000 accepted and completed normally.
- Reset asserted mid-write -> next cycle all outputs zero, state IDLE; ls_addr 0xFFFFFFFF half write -> mem_a 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serialising memory controller:
// request length codes, FSM states and length helpers.
package mem_ctrl_pkg;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Number of bus bytes for a request; the illegal code 11 acts as a word.
    function automatic logic [2:0] byte_count(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_BYTE: n = 3'd1;
            LEN_HALF: n = 3'd2;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

    // Keeps only the bytes a read of this length actually fetched.
    function automatic logic [31:0] len_mask(input logic [1:0] len);
        logic [31:0] m;
        case (len)
            LEN_BYTE: m = 32'h0000_00FF;
            LEN_HALF: m = 32'h0000_FFFF;
            default:  m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory request responder: arbitrates IF/MEM requests and serialises
// them into byte transactions on the 8-bit RAM/IO bus.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    input  logic                  if_flush_in,
    output logic                  if_done_out,
    input  logic                  ls_req_in,
    input  logic                  ls_we_in,
    input  logic [1:0]            ls_len_in,
    input  logic [ADDR_WIDTH-1:0] ls_addr_in,
    input  logic [31:0]           ls_wdata_in,
    output logic                  ls_done_out,
    output logic [31:0]           rdata_out,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [31:0]           r_wdata;
    logic [1:0]            r_len;
    logic                  r_is_if;
    logic [1:0]            r_cnt;
    logic                  r_phase;
    logic [31:0]           r_buf;
    logic [31:0]           r_rdata;
    logic [ADDR_WIDTH-1:0] r_mem_a;
    logic [7:0]            r_dout;
    logic                  r_wr;
    logic                  r_if_done;
    logic                  r_ls_done;

    logic                  w_if_acc;
    logic                  w_abort;
    logic                  w_last;
    logic [2:0]            w_n;
    logic [1:0]            w_last_idx;
    logic [1:0]            w_cnt_inc;
    logic [7:0]            w_next_byte;
    logic [31:0]           w_asm;

    assign w_if_acc    = !ls_req_in && if_req_in && !if_flush_in;
    assign w_abort     = (r_state == ST_READ) && r_is_if && if_flush_in;
    assign w_n         = byte_count(r_len);
    assign w_last_idx  = 2'(w_n - 3'd1);
    assign w_last      = (r_cnt == w_last_idx);
    assign w_cnt_inc   = r_cnt + 2'd1;
    assign w_next_byte = r_wdata[{w_cnt_inc, 3'b000} +: 8];

    // Final read word: captured bytes plus the byte on the bus, upper bytes cleared.
    always_comb begin
        w_asm = r_buf;
        w_asm[{r_cnt, 3'b000} +: 8] = mem_din;
        w_asm = w_asm & len_mask(r_len);
    end

    // Next-state logic; MEM wins arbitration, a flushed IF read is dropped.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (ls_req_in)
                    w_state_nxt = ls_we_in ? ST_WRITE : ST_READ;
                else if (w_if_acc)
                    w_state_nxt = ST_READ;
            end
            ST_READ: begin
                if (w_abort)
                    w_state_nxt = ST_IDLE;
                else if (r_phase && w_last)
                    w_state_nxt = ST_DONE;
            end
            ST_WRITE: begin
                if (w_last)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; a low rdy_in freezes the FSM.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_state <= ST_IDLE;
        else if (rdy_in)
            r_state <= w_state_nxt;
    end

    // Datapath: request latch, byte counter, bus drive and read assembly.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wdata   <= '0;
            r_len     <= LEN_BYTE;
            r_is_if   <= 1'b0;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
            r_buf     <= '0;
            r_rdata   <= '0;
            r_mem_a   <= '0;
            r_dout    <= '0;
            r_wr      <= 1'b0;
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
        end else if (rdy_in) begin
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (ls_req_in || w_if_acc) begin
                        r_is_if <= !ls_req_in;
                        r_len   <= ls_req_in ? ls_len_in : LEN_WORD;
                        r_mem_a <= ls_req_in ? ls_addr_in : if_addr_in;
                        r_wdata <= ls_wdata_in;
                        r_cnt   <= '0;
                        r_phase <= 1'b0;
                        if (ls_req_in && ls_we_in) begin
                            r_dout <= ls_wdata_in[7:0];
                            r_wr   <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (!w_abort) begin
                        if (r_phase) begin
                            r_buf[{r_cnt, 3'b000} +: 8] <= mem_din;
                            r_mem_a <= r_mem_a + ADDR_ONE;
                            r_cnt   <= w_cnt_inc;
                            r_phase <= 1'b0;
                            if (w_last) begin
                                r_rdata   <= w_asm;
                                r_if_done <= r_is_if;
                                r_ls_done <= !r_is_if;
                            end
                        end else begin
                            r_phase <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_last) begin
                        r_wr      <= 1'b0;
                        r_ls_done <= 1'b1;
                    end else begin
                        r_mem_a <= r_mem_a + ADDR_ONE;
                        r_dout  <= w_next_byte;
                        r_cnt   <= w_cnt_inc;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign if_done_out = r_if_done;
    assign ls_done_out = r_ls_done;
    assign rdata_out   = r_rdata;
    assign mem_a       = r_mem_a;
    assign mem_dout    = r_dout;
    assign mem_wr      = r_wr & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency byte RAM
// model on the bus; expected values are hand-computed per vector.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_flush_in;
    logic        if_done_out;
    logic        ls_req_in;
    logic        ls_we_in;
    logic [1:0]  ls_len_in;
    logic [31:0] ls_addr_in;
    logic [31:0] ls_wdata_in;
    logic        ls_done_out;
    logic [31:0] rdata_out;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .if_req_in   (if_req_in),
        .if_addr_in  (if_addr_in),
        .if_flush_in (if_flush_in),
        .if_done_out (if_done_out),
        .ls_req_in   (ls_req_in),
        .ls_we_in    (ls_we_in),
        .ls_len_in   (ls_len_in),
        .ls_addr_in  (ls_addr_in),
        .ls_wdata_in (ls_wdata_in),
        .ls_done_out (ls_done_out),
        .rdata_out   (rdata_out),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .mem_a       (mem_a),
        .mem_wr      (mem_wr)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // Synchronous RAM read: data for the address seen at an edge appears after it.
    always @(posedge clk_in) mem_din <= ram_rd(mem_a);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0] a_log [64];
    logic [7:0]  d_log [64];
    logic        w_log [64];
    int          if_cyc, ls_cyc, if_pulses, ls_pulses, wr_cnt;
    logic [31:0] if_data, ls_data;
    logic        both_seen;

    // Runs from cycle 0 (inputs already driven) until all requests complete.
    task automatic run(input int flush_at, input logic [31:0] new_if_addr,
                       input int pz_from, input int pz_len);
        int k;
        int last;
        k = 0;
        if_cyc = -1; ls_cyc = -1; if_pulses = 0; ls_pulses = 0; wr_cnt = 0;
        both_seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            a_log[i] = '0; d_log[i] = '0; w_log[i] = 1'b0;
        end
        rdy_in = !(k >= pz_from && k < pz_from + pz_len);
        if_flush_in = (k == flush_at);
        while (k < 60) begin
            @(negedge clk_in);
            a_log[k] = mem_a;
            d_log[k] = mem_dout;
            w_log[k] = mem_wr;
            if (mem_wr) begin
                wr_cnt++;
                ram[mem_a] = mem_dout;
            end
            if (if_done_out && ls_done_out) both_seen = 1'b1;
            if (if_done_out) begin
                if_pulses++;
                if (if_cyc < 0) begin
                    if_cyc = k; if_data = rdata_out; if_req_in = 1'b0;
                end
            end
            if (ls_done_out) begin
                ls_pulses++;
                if (ls_cyc < 0) begin
                    ls_cyc = k; ls_data = rdata_out; ls_req_in = 1'b0;
                end
            end
            last = (if_cyc > ls_cyc) ? if_cyc : ls_cyc;
            if (!if_req_in && !ls_req_in && k > last + 1) break;
            @(posedge clk_in);
            #1;
            k++;
            rdy_in = !(k >= pz_from && k < pz_from + pz_len);
            if_flush_in = (k == flush_at);
            if (k == flush_at) if_addr_in = new_if_addr;
        end
        if (k >= 60) chk("timeout", k, 0);
        chk("done_excl", {31'b0, both_seen}, 0);
        rdy_in = 1'b1;
        if_flush_in = 1'b0;
        if_req_in = 1'b0;
        ls_req_in = 1'b0;
    endtask

    task automatic start_ls(input logic we, input logic [1:0] len,
                            input logic [31:0] a, input logic [31:0] d);
        ls_req_in = 1'b1; ls_we_in = we; ls_len_in = len;
        ls_addr_in = a; ls_wdata_in = d;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        if_req_in = 1'b0; if_addr_in = '0; if_flush_in = 1'b0;
        ls_req_in = 1'b0; ls_we_in = 1'b0; ls_len_in = 2'b00;
        ls_addr_in = '0; ls_wdata_in = '0;
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h00;
        ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h93;
        ram[32'h2000] = 8'h11; ram[32'h2001] = 8'h22;
        ram[32'h2002] = 8'hEF; ram[32'h2003] = 8'hBE;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_outs", {if_done_out, ls_done_out, mem_wr, mem_dout}, 0);
        chk("rst_rdata", rdata_out, 0);

        // IF word read
        @(posedge clk_in); #1;
        if_req_in = 1'b1; if_addr_in = 32'h1000;
        run(-1, 0, -1, 0);
        chk("if_rd_cyc", if_cyc, 9);
        chk("if_rd_data", if_data, 32'h9300_0013);
        chk("if_rd_pulses", if_pulses, 1);
        chk("if_rd_a1", a_log[1], 32'h1000);
        chk("if_rd_a2", a_log[2], 32'h1000);
        chk("if_rd_a3", a_log[3], 32'h1001);
        chk("if_rd_a8", a_log[8], 32'h1003);

        // MEM byte write
        @(posedge clk_in); #1;
        start_ls(1'b1, 2'b00, 32'h30000, 32'h0000_0041);
        run(-1, 0, -1, 0);
        chk("bw_cyc", ls_cyc, 2);
        chk("bw_wr", {w_log[0], w_log[1], w_log[2]}, 3'b010);
        chk("bw_dout", d_log[1], 8'h41);
        chk("bw_cnt", wr_cnt, 1);
        chk("bw_ram", ram_rd(32'h30000), 8'h41);

        // Simultaneous requests: MEM half read first, then IF
        @(posedge clk_in); #1;
        if_req_in = 1'b1; if_addr_in = 32'h1000;
        start_ls(1'b0, 2'b01, 32'h2002, 32'h0);
        run(-1, 0, -1, 0);
        chk("arb_ls_cyc", ls_cyc, 5);
        chk("arb_ls_data", ls_data, 32'h0000_BEEF);
        chk("arb_if_cyc", if_cyc, 15);
        chk("arb_if_data", if_data, 32'h9300_0013);

        // Word write with a 3-cycle pause during byte 1
        @(posedge clk_in); #1;
        start_ls(1'b1, 2'b10, 32'h100, 32'hDDCC_BBAA);
        run(-1, 0, 2, 3);
        chk("pz_cyc", ls_cyc, 8);
        chk("pz_cnt", wr_cnt, 4);
        chk("pz_wr2", {31'b0, w_log[2]}, 0);
        chk("pz_ram", {ram_rd(32'h103), ram_rd(32'h102), ram_rd(32'h101), ram_rd(32'h100)},
            32'hDDCC_BBAA);

        // IF read flushed in cycle 4, redirected to 0x2000
        @(posedge clk_in); #1;
        if_req_in = 1'b1; if_addr_in = 32'h1000;
        run(4, 32'h2000, -1, 0);
        chk("fl_cyc", if_cyc, 14);
        chk("fl_pulses", if_pulses, 1);
        chk("fl_data", if_data, 32'hBEEF_2211);

        // Byte read clears the upper bytes left by the previous read
        @(posedge clk_in); #1;
        start_ls(1'b0, 2'b00, 32'h1003, 32'h0);
        run(-1, 0, -1, 0);
        chk("br_cyc", ls_cyc, 3);
        chk("br_data", ls_data, 32'h0000_0093);

        // Illegal length code reads a full word
        @(posedge clk_in); #1;
        start_ls(1'b0, 2'b11, 32'h2000, 32'h0);
        run(-1, 0, -1, 0);
        chk("l3_cyc", ls_cyc, 9);
        chk("l3_data", ls_data, 32'hBEEF_2211);

        // Reset in the middle of a word write
        @(posedge clk_in); #1;
        start_ls(1'b1, 2'b10, 32'h400, 32'h1234_5678);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1'b1; ls_req_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("mr_mem_a", mem_a, 0);
        chk("mr_outs", {if_done_out, ls_done_out, mem_wr, mem_dout}, 0);
        chk("mr_rdata", rdata_out, 0);

        // Half write wrapping past the top of the address space
        @(posedge clk_in); #1;
        start_ls(1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000_5A6B);
        run(-1, 0, -1, 0);
        chk("wr_cyc", ls_cyc, 3);
        chk("wr_a1", a_log[1], 32'hFFFF_FFFF);
        chk("wr_a2", a_log[2], 32'h0000_0000);
        chk("wr_d", {d_log[1], d_log[2]}, 16'h6B5A);
        chk("wr_ram", {ram_rd(32'hFFFF_FFFF), ram_rd(32'h0)}, 16'h6B5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
